// File: rtl/enc_bundle_acc_if.sv
// Query result handshake between the bundling accumulator and the associative-memory search stage.
interface enc_bundle_acc_if #(
  parameter int HV_DIM = 512
);
  logic [HV_DIM-1:0]            query_hv;
  logic [$clog2(HV_DIM+1)-1:0]  query_popcnt;
  logic                         query_valid;
  logic                         query_ready;

  modport master (output query_hv, query_popcnt, query_valid, input query_ready);
  modport slave  (input query_hv, query_popcnt, query_valid, output query_ready);
endinterface

// File: rtl/enc_bundle_acc.sv
// Per-bit bundling accumulator: sums bound hypervectors, thresholds into a held query.
// Optional ctr sequence checking is built when ENC_BUNDLE_SEQ_CHECK_EN is defined.
module enc_bundle_acc #(
  parameter int HV_DIM          = 512,
  parameter int SEQ_CYCLE_COUNT = 16,
  parameter int THRESH          = 2,
  parameter int CNT_W           = $clog2(SEQ_CYCLE_COUNT + 1)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   en,
  input  logic                   bundling_features,
  input  logic [3:0]             ctr,
  input  logic                   encoding_done,
  input  logic [HV_DIM-1:0]      bound_hv,
  enc_bundle_acc_if.master       q,
  output logic                   overrun,
  input  logic                   clr_overrun,
  output logic                   seq_err
);
  localparam int PW = $clog2(HV_DIM + 1);

  typedef enum logic {A_IDLE, A_ACC} acc_state_t;
  acc_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt [HV_DIM];
  logic [HV_DIM-1:0] thr;
  logic [PW-1:0]     thr_pop;
  logic load, add, cap, accept, drop;

  assign load   = bundling_features && en && (ctr == 4'd0);
  assign add    = (state == A_ACC) && bundling_features && en && (ctr != 4'd0);
  assign cap    = (state == A_ACC) && encoding_done && en;
  assign accept = q.query_valid && q.query_ready;
  assign drop   = cap && q.query_valid && !q.query_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= A_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load)     state_nxt = A_ACC;
    else if (cap) state_nxt = A_IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < HV_DIM; i++) cnt[i] <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < HV_DIM; i++) cnt[i] <= CNT_W'(bound_hv[i]);
    end else if (add) begin
      for (int unsigned i = 0; i < HV_DIM; i++)
        if (cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(bound_hv[i]);
    end
  end

  always_comb begin
    thr     = '0;
    thr_pop = '0;
    for (int unsigned i = 0; i < HV_DIM; i++) begin
      thr[i]  = (cnt[i] >= CNT_W'(THRESH));
      thr_pop = thr_pop + PW'(thr[i]);
    end
  end

  // A capture that is not dropped wins over a same-cycle accept, keeping valid high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q.query_hv     <= '0;
      q.query_popcnt <= '0;
      q.query_valid  <= 1'b0;
    end else if (cap && !drop) begin
      q.query_hv     <= thr;
      q.query_popcnt <= thr_pop;
      q.query_valid  <= 1'b1;
    end else if (accept) begin
      q.query_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)            overrun <= 1'b0;
    else if (clr_overrun) overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
  end

`ifdef ENC_BUNDLE_SEQ_CHECK_EN
  logic [3:0]     prev_ctr;
  logic [CNT_W:0] n_bund;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_ctr <= '0;
      n_bund   <= '0;
      seq_err  <= 1'b0;
    end else begin
      if (load) begin
        prev_ctr <= ctr;
        n_bund   <= (CNT_W+1)'(1);
      end else if (add) begin
        prev_ctr <= ctr;
        if (n_bund != '1) n_bund <= n_bund + (CNT_W+1)'(1);
        if (ctr != prev_ctr + 4'd1) seq_err <= 1'b1;
      end
      if (cap && (n_bund != (CNT_W+1)'(SEQ_CYCLE_COUNT))) seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule
